// File: rtl/adc_sam_if.sv
// Request/result bundle between adc_sam and its consumer.
interface adc_sam_if;
    logic       sam_start;
    logic [7:0] dout;
    logic       sam_end;
    logic       busy;

    modport master (
        output sam_start,
        input  dout,
        input  sam_end,
        input  busy
    );

    modport slave (
        input  sam_start,
        output dout,
        output sam_end,
        output busy
    );
endinterface

// File: rtl/adc_sam.sv
// Serial front end for an 8-bit TLC549-class ADC.
// Define ADC_SAM_FLUSH_EN to discard the first frame after reset.
module adc_sam #(
    parameter int CLK_DIV   = 25,
    parameter int CS_SETUP  = 70,
    parameter int CONV_WAIT = 850
) (
    input  logic      s_clk,
    input  logic      s_rst,
    adc_sam_if.slave  sam,
    input  logic      adc_sdo,
    output logic      adc_cs_n,
    output logic      adc_sclk
);

    localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAXC = (M1 > CONV_WAIT) ? M1 : CONV_WAIT;
    localparam int CW   = $clog2(MAXC + 1);

`ifdef ADC_SAM_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        CONV
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    hp;
    logic [7:0]    sr;
    logic [7:0]    dout_r;
    logic          end_r;
    logic          busy_r;
    logic          flush;
    logic          sdo_q1;
    logic          sdo_s;

    assign sam.dout    = dout_r;
    assign sam.sam_end = end_r;
    assign sam.busy    = busy_r;

    always_ff @(posedge s_clk) begin
        sdo_q1 <= adc_sdo;
        sdo_s  <= sdo_q1;
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hp       <= '0;
            sr       <= '0;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
            dout_r   <= '0;
            end_r    <= 1'b0;
            busy_r   <= 1'b0;
            flush    <= FLUSH_EN;
        end else begin
            end_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sam.sam_start) begin
                        state    <= SETUP;
                        cnt      <= '0;
                        adc_cs_n <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(CS_SETUP - 1)) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        hp    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        cnt      <= '0;
                        hp       <= hp + 1'b1;
                        adc_sclk <= ~adc_sclk;
                        if (adc_sclk) begin
                            sr <= {sr[6:0], sdo_s};
                        end
                        // odd half-phase 15 is the 8th high phase
                        if (hp == 4'd15) begin
                            state    <= CONV;
                            adc_cs_n <= 1'b1;
                            adc_sclk <= 1'b0;
                            if (!flush) begin
                                dout_r <= {sr[6:0], sdo_s};
                                end_r  <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONV: begin
                    if (cnt == CW'(CONV_WAIT - 1)) begin
                        cnt <= '0;
                        if (flush) begin
                            flush    <= 1'b0;
                            state    <= SETUP;
                            adc_cs_n <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sam.sv
// Self-checking bench for adc_sam with a behavioural TLC549 model.
// Flush-frame checks build only with ADC_SAM_FLUSH_EN defined.
module tb_adc_sam;

    localparam int DIV  = 4;
    localparam int CSS  = 3;
    localparam int CWT  = 10;
    localparam int T    = 1 + CSS + 16 * DIV;
    localparam int P    = T + CWT;
    localparam int MAXT = 200;

    logic s_clk = 1'b0;
    logic s_rst = 1'b1;
    logic adc_sdo = 1'b0;
    logic adc_cs_n;
    logic adc_sclk;

    adc_sam_if sam ();

    adc_sam #(
        .CLK_DIV   (DIV),
        .CS_SETUP  (CSS),
        .CONV_WAIT (CWT)
    ) dut (
        .s_clk    (s_clk),
        .s_rst    (s_rst),
        .sam      (sam),
        .adc_sdo  (adc_sdo),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk)
    );

    always #5 s_clk = ~s_clk;

    // ADC: loads a byte at CS fall, presents MSB, next bit after each SCLK fall
    logic [7:0] adc_q[$];
    logic [7:0] cur = 8'h00;
    int         idx = 0;

    always @(negedge adc_cs_n) begin
        if (adc_q.size() > 0) cur = adc_q.pop_front();
        else cur = 8'($urandom);
        idx = 7;
        adc_sdo = cur[7];
    end

    always @(negedge adc_sclk) begin
        if (adc_cs_n === 1'b0 && idx > 0) begin
            idx = idx - 1;
            adc_sdo = cur[idx];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic       tr_cs[MAXT];
    logic       tr_sc[MAXT];
    logic       tr_se[MAXT];
    logic       tr_bz[MAXT];
    logic [7:0] tr_do[MAXT];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge s_clk);
        #1;
        cyc++;
    endtask

    task automatic sample(input int t);
        tr_cs[t] = adc_cs_n;
        tr_sc[t] = adc_sclk;
        tr_se[t] = sam.sam_end;
        tr_bz[t] = sam.busy;
        tr_do[t] = sam.dout;
    endtask

    // current cycle is t=0 and carries sam_start=1
    task automatic run(input int n, input int mode, input int p1,
                       input int p2, input int rst_at);
        sam.sam_start = 1'b1;
        sample(0);
        for (int t = 1; t <= n; t++) begin
            tick();
            sample(t);
            if (mode == 1) sam.sam_start = (t < 150);
            else sam.sam_start = (t == p1 || t == p2);
            s_rst = (t == rst_at);
        end
        sam.sam_start = 1'b0;
        s_rst = 1'b0;
    endtask

    function automatic int se_count(input int n);
        int c = 0;
        for (int t = 0; t <= n; t++) if (tr_se[t] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_se(input int n);
        for (int t = 0; t <= n; t++) if (tr_se[t] === 1'b1) return t;
        return -1;
    endfunction

    typedef struct {
        logic [7:0] data;
        int         p1;
        int         p2;
        int         rst_at;
        int         se_at;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[6];

    task automatic random_test();
        int         last_a = -100000;
        int         free = 0;
        int         frames = 0;
        int         ndone = 0;
        int         mb = 0, mc = 0, ms = 0, md = 0;
        logic       eb, ecs, ese, s;
        logic [7:0] b;
        logic [7:0] exp_q[$];
        adc_q.delete();
        for (int c = 0; c < 3000; c++) begin
            if (frames >= 8 && c >= free) break;
            if (c > 0) tick();
            eb  = (c > last_a) && (c < free);
            ecs = !((c > last_a) && (c < last_a + T));
            ese = (c == last_a + T);
            if (sam.busy !== eb) mb++;
            if (adc_cs_n !== ecs) mc++;
            if (sam.sam_end !== ese) ms++;
            if (ese) begin
                ndone++;
                if (exp_q.size() == 0) md++;
                else begin
                    b = exp_q.pop_front();
                    if (sam.dout !== b) md++;
                end
            end
            s = ($urandom_range(0, 2) == 0);
            sam.sam_start = s;
            if (s && c >= free) begin
                last_a = c;
                free = c + P;
                b = 8'($urandom);
                adc_q.push_back(b);
                exp_q.push_back(b);
                frames++;
            end
        end
        sam.sam_start = 1'b0;
        chk("rnd_busy_mism", mb, 0);
        chk("rnd_cs_mism", mc, 0);
        chk("rnd_end_mism", ms, 0);
        chk("rnd_dout_mism", md, 0);
        chk("rnd_frames_done", ndone, frames);
        chk("rnd_enough_frames", (frames >= 8) ? 1 : 0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        sam.sam_start = 1'b0;
        s_rst = 1'b1;
        repeat (3) tick();
        s_rst = 1'b0;
        tick();
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sclk", adc_sclk, 0);
        chk("rst_busy", sam.busy, 0);
        chk("rst_end", sam.sam_end, 0);
        chk("rst_dout", sam.dout, 8'h00);

`ifdef ADC_SAM_FLUSH_EN
        begin
            int falls = 0;
            int bm = 0;
            adc_q.delete();
            adc_q.push_back(8'h11);
            adc_q.push_back(8'h22);
            run(170, 0, -1, -1, -1);
            for (int t = 1; t <= 170; t++)
                if (tr_cs[t-1] === 1'b1 && tr_cs[t] === 1'b0) falls++;
            for (int t = 1; t < 155; t++) if (tr_bz[t] !== 1'b1) bm++;
            chk("fl_cs_falls", falls, 2);
            chk("fl_cs_fall2", tr_cs[78], 0);
            chk("fl_no_end68", tr_se[68], 0);
            chk("fl_first_end", first_se(170), 145);
            chk("fl_end_count", se_count(170), 1);
            chk("fl_dout", tr_do[145], 8'h22);
            chk("fl_busy_hold", bm, 0);
            chk("fl_busy_low", tr_bz[155], 0);
            tick();
        end
`else
        vecs[0] = '{8'hA5, -1, -1, -1, T, 8'hA5};
        vecs[1] = '{8'h00, -1, -1, -1, T, 8'h00};
        vecs[2] = '{8'hFF, -1, -1, -1, T, 8'hFF};
        vecs[3] = '{8'h5A, 30, 77, -1, T, 8'h5A};
        vecs[4] = '{8'h77, -1, -1, 40, -1, 8'h00};
        vecs[5] = '{8'h96, -1, -1, -1, T, 8'h96};

        for (int i = 0; i < 6; i++) begin
            int dm;
            int ch;
            logic esc;
            adc_q.delete();
            adc_q.push_back(vecs[i].data);
            run(90, 0, vecs[i].p1, vecs[i].p2, vecs[i].rst_at);
            chk($sformatf("v%0d_cs_low1", i), tr_cs[1], 0);
            chk($sformatf("v%0d_busy1", i), tr_bz[1], 1);
            chk($sformatf("v%0d_end_at", i), first_se(90), vecs[i].se_at);
            chk($sformatf("v%0d_end_cnt", i), se_count(90),
                (vecs[i].se_at < 0) ? 0 : 1);
            if (vecs[i].se_at >= 0) begin
                chk($sformatf("v%0d_dout", i), tr_do[vecs[i].se_at],
                    vecs[i].exp_dout);
                chk($sformatf("v%0d_busy_p-1", i), tr_bz[P-1], 1);
                chk($sformatf("v%0d_busy_p", i), tr_bz[P], 0);
                dm = 0;
                for (int t = 1; t < T; t++) begin
                    esc = (t >= 1 + CSS) &&
                          (((t - 1 - CSS) % (2 * DIV)) >= DIV);
                    if (tr_sc[t] !== esc) dm++;
                end
                chk($sformatf("v%0d_sclk_shape", i), dm, 0);
            end
            if (vecs[i].p1 > 0) begin
                ch = 0;
                for (int t = T; t <= 80; t++) if (tr_cs[t] !== 1'b1) ch++;
                chk($sformatf("v%0d_cs_high", i), ch, 0);
            end
            if (vecs[i].rst_at >= 0) begin
                chk($sformatf("v%0d_r_cs", i), tr_cs[vecs[i].rst_at+1], 1);
                chk($sformatf("v%0d_r_sclk", i), tr_sc[vecs[i].rst_at+1], 0);
                chk($sformatf("v%0d_r_busy", i), tr_bz[vecs[i].rst_at+1], 0);
                chk($sformatf("v%0d_r_dout", i), tr_do[vecs[i].rst_at+1], 0);
                chk($sformatf("v%0d_r_dout_end", i), tr_do[90], 0);
            end
            tick();
        end

        begin
            int hm = 0;
            adc_q.delete();
            adc_q.push_back(8'h3C);
            adc_q.push_back(8'hC3);
            run(160, 1, -1, -1, -1);
            chk("b2b_end1", first_se(160), T);
            chk("b2b_dout1", tr_do[T], 8'h3C);
            chk("b2b_cs_hi78", tr_cs[78], 1);
            chk("b2b_cs_lo79", tr_cs[79], 0);
            chk("b2b_end2", tr_se[146], 1);
            chk("b2b_end_cnt", se_count(160), 2);
            chk("b2b_dout2", tr_do[146], 8'hC3);
            for (int t = T + 1; t < 146; t++) if (tr_do[t] !== 8'h3C) hm++;
            chk("b2b_dout_hold", hm, 0);
            tick();
        end
`endif

        random_test();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
